// File: rtl/priority_arbiter4_if.sv
// Request/grant bundle between requesters and the 4-way priority arbiter.
// The master side drives requests and the policy select, the slave (arbiter)
// side returns the registered grant information.
interface priority_arbiter4_if;
  logic [3:0] req;
  logic       rr_mode;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  modport master (
    output req,
    output rr_mode,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  preempt
  );

  modport slave (
    input  req,
    input  rr_mode,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output preempt
  );
endinterface

// File: rtl/priority_arbiter4.sv
// 4-requester arbiter with fixed-priority or round-robin selection and a
// bounded hold time. An owner keeps the grant while it requests; after
// MAX_HOLD consecutive cycles the grant is rotated straight to another active
// requester (flagged by a one-cycle preempt pulse). A voluntary release always
// passes through one IDLE cycle before the next arbitration.
module priority_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  priority_arbiter4_if.slave    bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  state_t     state, state_nxt;
  logic [1:0] owner, owner_nxt;
  logic [1:0] last_id, last_id_nxt;
  logic [7:0] hold_cnt, hold_cnt_nxt;
  logic       mode, mode_nxt;
  logic       preempt_nxt;
  logic [3:0] others;

  logic [3:0] gnt_nxt;
  logic [1:0] gnt_id_nxt;
  logic       gnt_valid_nxt;

  // Fixed priority: the highest set index wins (later loop hits overwrite).
  function automatic logic [1:0] pick_fixed(input logic [3:0] r);
    logic [1:0] w;
    w = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) w = 2'(i);
    end
    return w;
  endfunction

  // Round-robin: first set bit searching upward from last+1 with wrap.
  function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] w;
    logic [1:0] idx;
    logic       found;
    w     = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [1:0] pick(input logic [3:0] r, input logic use_rr,
                                      input logic [1:0] last);
    return use_rr ? pick_rr(r, last) : pick_fixed(r);
  endfunction

  // State register; every architectural flop, including the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= 2'd0;
      last_id       <= 2'd3;
      hold_cnt      <= 8'd0;
      mode          <= 1'b0;
      bus.gnt       <= 4'b0000;
      bus.gnt_id    <= 2'd0;
      bus.gnt_valid <= 1'b0;
      bus.preempt   <= 1'b0;
    end else begin
      state         <= state_nxt;
      owner         <= owner_nxt;
      last_id       <= last_id_nxt;
      hold_cnt      <= hold_cnt_nxt;
      mode          <= mode_nxt;
      bus.gnt       <= gnt_nxt;
      bus.gnt_id    <= gnt_id_nxt;
      bus.gnt_valid <= gnt_valid_nxt;
      bus.preempt   <= preempt_nxt;
    end
  end

  // Next-state logic: arbitration from IDLE, hold / release / forced rotation in BUSY.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    last_id_nxt  = last_id;
    hold_cnt_nxt = hold_cnt;
    mode_nxt     = mode;
    preempt_nxt  = 1'b0;
    others       = bus.req & ~(4'b0001 << owner);
    unique case (state)
      IDLE: begin
        if (bus.req != 4'b0000) begin
          state_nxt    = BUSY;
          mode_nxt     = bus.rr_mode;
          owner_nxt    = pick(bus.req, bus.rr_mode, last_id);
          last_id_nxt  = owner_nxt;
          hold_cnt_nxt = 8'd1;
        end
      end
      BUSY: begin
        if (!bus.req[owner]) begin
          // Release wins over any simultaneous hold-limit event.
          state_nxt    = IDLE;
          hold_cnt_nxt = 8'd0;
        end else if (hold_cnt == HOLD_LIMIT) begin
          hold_cnt_nxt = 8'd1;
          if (others != 4'b0000) begin
            owner_nxt   = pick(others, mode, last_id);
            last_id_nxt = owner_nxt;
            preempt_nxt = 1'b1;
          end
        end else begin
          hold_cnt_nxt = hold_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode of the next state; gnt stays one-hot and matches gnt_id.
  always_comb begin
    gnt_nxt       = 4'b0000;
    gnt_id_nxt    = 2'd0;
    gnt_valid_nxt = 1'b0;
    if (state_nxt == BUSY) begin
      gnt_nxt       = 4'b0001 << owner_nxt;
      gnt_id_nxt    = owner_nxt;
      gnt_valid_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_priority_arbiter4.sv
// Self-checking bench for priority_arbiter4: directed scenarios followed by
// randomized traffic, all compared against a behavioural ownership model.
module tb_priority_arbiter4;

  localparam int MAX_HOLD = 8;

  logic clk;
  logic rst;
  priority_arbiter4_if bus ();

  priority_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner index (-1 when nobody holds), hold time, last owner.
  int m_owner = -1;
  int m_hold  = 0;
  int m_last  = 3;
  bit m_mode  = 1'b0;
  bit m_pre   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_pick(input bit [3:0] r, input bit use_rr, input int last);
    if (use_rr) begin
      for (int k = 1; k <= 4; k++) begin
        if (r[(last + k) % 4]) return (last + k) % 4;
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (r[i]) return i;
      end
    end
    return -1;
  endfunction

  task automatic model_edge(input bit r_rst, input bit [3:0] r, input bit rr);
    bit [3:0] oth;
    int w;
    if (r_rst) begin
      m_owner = -1; m_hold = 0; m_last = 3; m_pre = 1'b0;
    end else if (m_owner < 0) begin
      m_pre = 1'b0;
      if (r != 4'b0000) begin
        m_mode  = rr;
        m_owner = m_pick(r, rr, m_last);
        m_last  = m_owner;
        m_hold  = 1;
      end
    end else if (!r[m_owner]) begin
      m_owner = -1; m_hold = 0; m_pre = 1'b0;
    end else if (m_hold == MAX_HOLD) begin
      oth = r;
      oth[m_owner] = 1'b0;
      m_hold = 1;
      m_pre  = 1'b0;
      if (oth != 4'b0000) begin
        w = m_pick(oth, m_mode, m_last);
        m_owner = w; m_last = w; m_pre = 1'b1;
      end
    end else begin
      m_hold++;
      m_pre = 1'b0;
    end
  endtask

  // One clock: apply inputs, advance model at the edge, compare 1 time unit later.
  task automatic step(input string tag, input bit r_rst, input bit [3:0] r, input bit rr);
    logic [3:0] e_gnt;
    rst = r_rst; bus.req = r; bus.rr_mode = rr;
    @(posedge clk);
    model_edge(r_rst, r, rr);
    #1;
    e_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    chk({tag, ".gnt"},       32'(bus.gnt),       32'(e_gnt));
    chk({tag, ".gnt_id"},    32'(bus.gnt_id),    (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(m_owner >= 0));
    chk({tag, ".preempt"},   32'(bus.preempt),   32'(m_pre));
  endtask

  initial begin
    bit [3:0] rq;
    bit       rm;
    bit       rr_rst;
    rst = 1'b1; bus.req = 4'b0000; bus.rr_mode = 1'b0;
    #2;

    // Reset state
    step("reset", 1'b1, 4'b1111, 1'b1);
    chk("reset.gnt_const", 32'(bus.gnt), 32'h0);

    // Fixed priority, release gap, re-arbitration
    step("fp.grant", 1'b0, 4'b0111, 1'b0);
    chk("fp.grant_const", 32'(bus.gnt), 32'h4);
    chk("fp.id_const", 32'(bus.gnt_id), 32'd2);
    step("fp.release", 1'b0, 4'b0011, 1'b0);
    chk("fp.idle_valid", 32'(bus.gnt_valid), 32'd0);
    step("fp.regrant", 1'b0, 4'b0011, 1'b0);
    chk("fp.regrant_const", 32'(bus.gnt), 32'h2);

    // Round-robin sequence 0,1,2,3,0 after reset
    step("rr.reset", 1'b1, 4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step("rr.grant", 1'b0, 4'b1111, 1'b1);
      chk("rr.order", 32'(bus.gnt_id), 32'(k % 4));
      step("rr.hold", 1'b0, 4'b1111, 1'b1);
      step("rr.release", 1'b0, 4'b1111 & ~(4'b0001 << (k % 4)), 1'b1);
      chk("rr.gap", 32'(bus.gnt_valid), 32'd0);
    end

    // Forced rotation after MAX_HOLD cycles
    step("rot.reset", 1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) step("rot.alone", 1'b0, 4'b1000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("rot.held", 1'b0, 4'b1001, 1'b0);
      chk("rot.held_const", 32'(bus.gnt), 32'h8);
    end
    step("rot.switch", 1'b0, 4'b1001, 1'b0);
    chk("rot.switch_gnt", 32'(bus.gnt), 32'h1);
    chk("rot.switch_pre", 32'(bus.preempt), 32'd1);
    step("rot.after", 1'b0, 4'b1001, 1'b0);
    chk("rot.after_pre", 32'(bus.preempt), 32'd0);

    // Lone holder never pre-empted
    step("lone.reset", 1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step("lone", 1'b0, 4'b0010, 1'b0);
      chk("lone.gnt_const", 32'(bus.gnt), 32'h2);
      chk("lone.pre_const", 32'(bus.preempt), 32'd0);
    end

    // Release coinciding with the hold limit
    step("coin.reset", 1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 8; i++) step("coin.hold", 1'b0, 4'b1001, 1'b0);
    step("coin.release", 1'b0, 4'b0001, 1'b0);
    chk("coin.valid", 32'(bus.gnt_valid), 32'd0);
    chk("coin.pre", 32'(bus.preempt), 32'd0);

    // Reset in the middle of a grant
    step("mid.grant", 1'b0, 4'b1111, 1'b0);
    step("mid.rst", 1'b1, 4'b1111, 1'b1);
    chk("mid.rst_gnt", 32'(bus.gnt), 32'h0);
    step("mid.first", 1'b0, 4'b0110, 1'b1);
    chk("mid.first_id", 32'(bus.gnt_id), 32'd1);

    // Randomized traffic with sticky requests and occasional resets
    rq = 4'b0000;
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(5) == 0) rq[b] = ~rq[b];
      end
      rm     = 1'($urandom_range(1));
      rr_rst = ($urandom_range(149) == 0);
      step("rand", rr_rst, rq, rm);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
